// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I control path: FSM states, opcodes, select codes.
package rv32i_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_R    = 7'd51;
  localparam logic [OP_W-1:0] OP_I    = 7'd19;
  localparam logic [OP_W-1:0] OP_LW   = 7'd3;
  localparam logic [OP_W-1:0] OP_SW   = 7'd35;
  localparam logic [OP_W-1:0] OP_B    = 7'd99;
  localparam logic [OP_W-1:0] OP_JAL  = 7'd111;
  localparam logic [OP_W-1:0] OP_JALR = 7'd103;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b000;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format mapping, shared with the pipelined core.
module imm_src_decoder
  import rv32i_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output logic [1:0]      imm_src_o
);

  // Branch, jump and store formats are special; everything else is I-type.
  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_B:    imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      OP_SW:   imm_src_o = IMM_S;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM of the multi-cycle RV32I core with retired-instruction counter.
module multicycle_controller
  import rv32i_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         imm_src,
  output logic [1:0]         result_src,
  output logic               illegal_instr,
  output logic [D_WIDTH-1:0] instret
);

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] instret_q, instret_d;
  logic [1:0]         imm_dec_c;
  logic               legal_c;
  logic               retire_c;

  imm_src_decoder u_imm_dec (
    .op_i      (op),
    .imm_src_o (imm_dec_c)
  );

  // Supported opcode / funct combinations.
  always_comb begin
    legal_c = 1'b0;
    case (op)
      OP_R:            legal_c = (funct3 == 3'b000) && !funct7;
      OP_I:            legal_c = (funct3 == 3'b000);
      OP_LW, OP_SW:    legal_c = (funct3 == 3'b010);
      OP_B:            legal_c = (funct3 == 3'b000) || (funct3 == 3'b001);
      OP_JAL, OP_JALR: legal_c = 1'b1;
      default:         legal_c = 1'b0;
    endcase
  end

  // State and retired-instruction counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and datapath controls; everything held inactive while in reset.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_control   = ALU_ADD;
    imm_src       = IMM_I;
    result_src    = RES_ALUOUT;
    illegal_instr = 1'b0;
    retire_c      = 1'b0;

    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = imm_dec_c;
          if (!legal_c) begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end else begin
            case (op)
              OP_LW, OP_SW: state_d = S_MEMADR;
              OP_R:         state_d = S_EXECR;
              OP_I:         state_d = S_EXECI;
              OP_B:         state_d = S_BRANCH;
              OP_JAL:       state_d = S_JAL;
              default:      state_d = S_JALR;
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          state_d   = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_RS2;
          alu_control = ALU_SUB;
          result_src  = RES_ALUOUT;
          pc_write    = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
          retire_c    = 1'b1;
          state_d     = S_FETCH;
        end
        S_JALR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          state_d   = S_JAL;
        end
        S_JAL: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALUOUT;
          pc_write   = 1'b1;
          state_d    = S_ALUWB;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Counter advances on the edge that leaves a retiring state; wraps naturally.
  always_comb begin
    instret_d = instret_q + D_WIDTH'(retire_c);
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench: per-instruction cycle model feeds an expected queue.
module tb_multicycle_controller;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_control;
  logic        illegal_instr;
  logic [31:0] instret;

  multicycle_controller #(.D_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .result_src(result_src), .illegal_instr(illegal_instr),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus plus the responses expected during it.
  typedef struct {
    bit          rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          f7;
    bit          zero;
    bit          ready;
    logic [15:0] outs;
    bit          chk_imm;
    logic [1:0]  imm;
    logic [31:0] instret;
  } rec_t;

  rec_t        plan[$];
  rec_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 0;
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  bit          cur_f7, cur_zero;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // {req,wr,adr,irw,pcw,rw,ill,a,b,alu,res}
  function automatic logic [15:0] o(bit req, bit wr, bit adr, bit irw, bit pcw, bit rw,
                                     bit ill, logic [1:0] a, logic [1:0] b,
                                     logic [2:0] alu, logic [1:0] res);
    return {req, wr, adr, irw, pcw, rw, ill, a, b, alu, res};
  endfunction

  function automatic bit legal(logic [6:0] opc, logic [2:0] f3, bit f7);
    case (opc)
      7'd51:         return (f3 == 3'd0) && !f7;
      7'd19:         return f3 == 3'd0;
      7'd3, 7'd35:   return f3 == 3'd2;
      7'd99:         return f3 <= 3'd1;
      7'd111, 7'd103: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] opc);
    if (opc == 7'd99) return 2'd2;
    if (opc == 7'd111) return 2'd3;
    if (opc == 7'd35) return 2'd1;
    return 2'd0;
  endfunction

  function automatic void add(bit r, bit ready, logic [15:0] outs, bit ci, logic [1:0] imm,
                              bit retire);
    rec_t x;
    x.rst = r; x.op = cur_op; x.f3 = cur_f3; x.f7 = cur_f7; x.zero = cur_zero;
    x.ready = ready; x.outs = outs; x.chk_imm = ci; x.imm = imm; x.instret = model_cnt;
    plan.push_back(x);
    if (retire) model_cnt = model_cnt + 32'd1;
  endfunction

  function automatic void add_reset();
    model_cnt = 0;
    add(1'b1, rb(), o(0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd1, 2'd0), 1'b0, 2'd0, 1'b0);
  endfunction

  // Expected cycle sequence of one instruction, from the instruction-level timing rules.
  function automatic void gen(logic [6:0] opc, logic [2:0] f3, bit f7, bit z,
                              int fw, int mw, bit rst_in_mem);
    logic [15:0] wb, jal, rq;
    bit taken;
    cur_op = opc; cur_f3 = f3; cur_f7 = f7; cur_zero = z;
    wb  = o(0,0,0,0,0,1,0, 2'd0, 2'd0, 3'd1, 2'd0);
    jal = o(0,0,0,0,1,0,0, 2'd1, 2'd2, 3'd1, 2'd0);
    for (int i = 0; i < fw; i++) add(1'b0, 1'b0, o(1,0,0,0,0,0,0, 2'd0, 2'd2, 3'd1, 2'd2), 1'b0, 2'd0, 1'b0);
    add(1'b0, 1'b1, o(1,0,0,1,1,0,0, 2'd0, 2'd2, 3'd1, 2'd2), 1'b0, 2'd0, 1'b0);
    if (!legal(opc, f3, f7)) begin
      add(1'b0, rb(), o(0,0,0,0,0,0,1, 2'd1, 2'd1, 3'd1, 2'd0), 1'b1, imm_of(opc), 1'b0);
      return;
    end
    add(1'b0, rb(), o(0,0,0,0,0,0,0, 2'd1, 2'd1, 3'd1, 2'd0), 1'b1, imm_of(opc), 1'b0);
    case (opc)
      7'd51: begin
        add(1'b0, rb(), o(0,0,0,0,0,0,0, 2'd2, 2'd0, 3'd1, 2'd0), 1'b0, 2'd0, 1'b0);
        add(1'b0, rb(), wb, 1'b0, 2'd0, 1'b1);
      end
      7'd19: begin
        add(1'b0, rb(), o(0,0,0,0,0,0,0, 2'd2, 2'd1, 3'd1, 2'd0), 1'b0, 2'd0, 1'b0);
        add(1'b0, rb(), wb, 1'b0, 2'd0, 1'b1);
      end
      7'd3: begin
        add(1'b0, rb(), o(0,0,0,0,0,0,0, 2'd2, 2'd1, 3'd1, 2'd0), 1'b0, 2'd0, 1'b0);
        rq = o(1,0,1,0,0,0,0, 2'd0, 2'd0, 3'd1, 2'd0);
        for (int i = 0; i < mw; i++) add(1'b0, 1'b0, rq, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, rq, 1'b0, 2'd0, 1'b0);
        add(1'b0, rb(), o(0,0,0,0,0,1,0, 2'd0, 2'd0, 3'd1, 2'd1), 1'b0, 2'd0, 1'b1);
      end
      7'd35: begin
        add(1'b0, rb(), o(0,0,0,0,0,0,0, 2'd2, 2'd1, 3'd1, 2'd0), 1'b0, 2'd0, 1'b0);
        rq = o(1,1,1,0,0,0,0, 2'd0, 2'd0, 3'd1, 2'd0);
        if (rst_in_mem) begin
          add(1'b0, 1'b0, rq, 1'b0, 2'd0, 1'b0);
          add_reset();
          return;
        end
        for (int i = 0; i < mw; i++) add(1'b0, 1'b0, rq, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, rq, 1'b0, 2'd0, 1'b1);
      end
      7'd99: begin
        taken = (f3 == 3'd0) ? z : !z;
        add(1'b0, rb(), o(0,0,0,0,taken,0,0, 2'd2, 2'd0, 3'd0, 2'd0), 1'b0, 2'd0, 1'b1);
      end
      7'd111: begin
        add(1'b0, rb(), jal, 1'b0, 2'd0, 1'b0);
        add(1'b0, rb(), wb, 1'b0, 2'd0, 1'b1);
      end
      default: begin
        add(1'b0, rb(), o(0,0,0,0,0,0,0, 2'd2, 2'd1, 3'd1, 2'd0), 1'b0, 2'd0, 1'b0);
        add(1'b0, rb(), jal, 1'b0, 2'd0, 1'b0);
        add(1'b0, rb(), wb, 1'b0, 2'd0, 1'b1);
      end
    endcase
  endfunction

  // Stimulus: build the plan, then drive one record per cycle and post its expectation.
  initial begin
    logic [6:0] ops [0:9];
    int k;
    logic [2:0] f3;
    bit f7;
    ops[0] = 7'd51; ops[1] = 7'd19; ops[2] = 7'd3;  ops[3] = 7'd35; ops[4] = 7'd99;
    ops[5] = 7'd111; ops[6] = 7'd103; ops[7] = 7'h7F; ops[8] = 7'd0; ops[9] = 7'd99;
    rst = 1'b1; op = '0; funct3 = '0; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b0;

    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0; cur_zero = 1'b0;
    add_reset();
    add_reset();
    gen(7'd19, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    gen(7'd3, 3'd2, 1'b0, 1'b0, 0, 2, 1'b0);
    gen(7'd99, 3'd0, 1'b0, 1'b1, 0, 0, 1'b0);
    gen(7'd99, 3'd1, 1'b0, 1'b1, 0, 0, 1'b0);
    gen(7'd103, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    gen(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    gen(7'd35, 3'd2, 1'b0, 1'b0, 1, 2, 1'b1);
    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(0, 9);
      case (ops[k])
        7'd51:        f3 = 3'd0;
        7'd3, 7'd35:  f3 = 3'd2;
        7'd99:        f3 = 3'($urandom_range(0, 1));
        default:      f3 = 3'($urandom_range(0, 7));
      endcase
      f7 = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        f3 = 3'($urandom_range(0, 7));
        f7 = rb();
      end
      gen(ops[k], f3, f7, rb(), $urandom_range(0, 2), $urandom_range(0, 3),
          (n == 90) && (ops[k] == 7'd35) && legal(ops[k], f3, f7));
    end
    gen(7'd35, 3'd2, 1'b0, 1'b0, 0, 1, 1'b1);
    gen(7'd19, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    gen(7'd111, 3'd5, 1'b0, 1'b0, 1, 0, 1'b0);

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      rst = plan[i].rst; op = plan[i].op; funct3 = plan[i].f3; funct7 = plan[i].f7;
      zero = plan[i].zero; mem_ready = plan[i].ready;
      sb.push_back(plan[i]);
    end
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: compare combinational outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    rec_t r;
    logic [15:0] act;
    if (sb.size() != 0) begin
      r = sb.pop_front();
      act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr,
             alu_src_a, alu_src_b, alu_control, result_src};
      checks++;
      if (act !== r.outs) begin
        errors++;
        $display("FAIL ctrl t=%0t op=%0d: got %b required %b", $time, r.op, act, r.outs);
      end
      checks++;
      if (instret !== r.instret) begin
        errors++;
        $display("FAIL instret t=%0t: got %0d required %0d", $time, instret, r.instret);
      end
      if (r.chk_imm) begin
        checks++;
        if (imm_src !== r.imm) begin
          errors++;
          $display("FAIL imm_src t=%0t op=%0d: got %0d required %0d", $time, r.op, imm_src, r.imm);
        end
      end
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main sequencing FSM for the multi-cycle RV32I core.
- Replaces single-cycle decode: one shared ALU and one unified instruction/data memory, stepped through fetch/decode/execute/memory/writeback states.
- Drives datapath mux selects and write strobes, handshakes with memory through mem_req/mem_ready, and counts retired instructions.

Parameters:
- D_WIDTH, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  opcode field of the instruction register.
- funct3  in  3  instruction bits [14:12].
- funct7  in  1  instruction bit 30.
- zero  in  1  ALU zero flag, valid in the same cycle.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  the access is a store.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and the OldPC register.
- pc_write  out  1  load PC from the result bus.
- reg_write  out  1  write the result bus to rd.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_control  out  3  ALU operation: 001 = ADD, 000 = SUB.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- illegal_instr  out  1  one-cycle pulse on an unsupported instruction.
- instret  out  D_WIDTH  count of retired instructions.

Behaviour:
- Supported instructions:
  - ADD: op 51, funct3 000, funct7 0.
  - ADDI: op 19, funct3 000.
  - LW: op 3, funct3 010.
  - SW: op 35, funct3 010.
  - BEQ / BNE: op 99, funct3 000 / 001.
  - JAL: op 111.
  - JALR: op 103.
- Reset:
  - While rst is high, state = FETCH and instret = 0.
  - mem_req, mem_write, ir_write, pc_write, reg_write and illegal_instr are forced to 0; all selects are 00; alu_control = 001.
  - FETCH behaviour starts on the first edge after rst deasserts.
  - Reset mid-access abandons the access; no write strobe is emitted.
- Outputs are decoded combinationally from state. pc_write, ir_write and reg_write are additionally qualified by mem_ready or zero where stated below.
- Defaults in every state: all strobes 0, selects 00, alu_control = ADD.
- States and transitions:
  - FETCH: mem_req = 1, adr_src = 0, a = PC, b = 4, ADD, result_src = 10. When mem_ready = 1: ir_write = 1, pc_write = 1, go to DECODE. Otherwise hold FETCH with no strobes.
  - DECODE: a = OldPC, b = imm, ADD (ALUOut = branch/JAL target). imm_src follows op (B for 99, J for 111, S for 35, otherwise I). Next state:
    - 3 or 35 → MEMADR
    - 51 → EXECR
    - 19 → EXECI
    - 99 → BRANCH
    - 111 → JAL
    - 103 → JALR
    - anything else, or an unsupported funct3/funct7 → FETCH with illegal_instr = 1 and no other strobes.
  - MEMADR: a = rs1, b = imm, ADD. Go to MEMREAD if op = 3, MEMWRITE if op = 35.
  - MEMREAD: mem_req = 1, adr_src = 1. Wait for mem_ready, then go to MEMWB.
  - MEMWB: result_src = 01, reg_write = 1. Retire; go to FETCH.
  - MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. Wait for mem_ready, then retire and go to FETCH.
  - EXECR: a = rs1, b = rs2, ADD. Go to ALUWB.
  - EXECI: a = rs1, b = imm, ADD. Go to ALUWB.
  - ALUWB: result_src = 00, reg_write = 1. Retire; go to FETCH.
  - BRANCH: a = rs1, b = rs2, SUB, result_src = 00. pc_write = 1 when (funct3 = 000 and zero = 1) or (funct3 = 001 and zero = 0). Retire; go to FETCH.
  - JALR: a = rs1, b = imm, ADD (ALUOut becomes rs1 + imm). Go to JAL.
  - JAL: a = OldPC, b = 4, ADD, result_src = 00, pc_write = 1. Go to ALUWB, which writes ALUOut = OldPC + 4 to rd.
- Cycle counts with mem_ready tied high:
  - 3 cycles: BEQ, BNE.
  - 4 cycles: ADD, ADDI, SW, JAL.
  - 5 cycles: LW, JALR.
  - Each cycle with mem_ready low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Handshake:
  - mem_req holds high and the address is stable until mem_ready is seen.
  - mem_ready outside a request state is ignored.
- instret:
  - Increments by 1 on the edge leaving a retiring state (MEMWB, ALUWB, BRANCH, or MEMWRITE when mem_ready = 1).
  - Wraps modulo 2^D_WIDTH.
  - Illegal instructions do not increment it.

Decomposition:
- Shared package rv32i_pkg holds:
  - state_t enum.
  - Opcode constants: OP_R = 51, OP_I = 19, OP_LW = 3, OP_SW = 35, OP_B = 99, OP_JAL = 111, OP_JALR = 103.
  - ALU_ADD and ALU_SUB.
  - Select encodings for alu_src_a, alu_src_b, result_src and imm_src.
- One sub-module, imm_src_decoder: combinational op → imm_src mapping, reusable by the pipelined core.
- The FSM and the counter stay in multicycle_controller.

Test Plan:
- ADDI (op 19, funct3 0), mem_ready = 1 → states FETCH, DECODE, EXECI, ALUWB; reg_write = 1 only in cycle 4; instret 0 → 1.
- LW (op 3, funct3 010) with mem_ready low for 2 cycles in MEMREAD → mem_req high for 3 cycles with adr_src = 1; MEMWB asserts result_src = 01 and reg_write = 1; 7 cycles total.
- BEQ with zero = 1, then BNE with zero = 1 → pc_write = 1 in BRANCH for BEQ only; each takes 3 cycles; instret += 2.
- JALR (op 103) → DECODE, JALR (a = 10, b = 01), JAL (pc_write = 1, result_src = 00), ALUWB (reg_write = 1).
- op = 0x7F → illegal_instr high exactly 1 cycle in DECODE; back in FETCH next cycle; no reg/mem/pc writes; instret unchanged.
- SW with mem_ready low, rst asserted in MEMWRITE → mem_req and mem_write drop immediately; state = FETCH; instret = 0.
